sm83_reg_bus_seq: RTL

Sequencer and arbiter for the precharged SM83 register buses (A, B, C).
- Runs every bus transfer as precharge → drive → latch.
- Generates the active-low precharge enable `pch_n` and the C-bus zero-force `c_zero` for the bus precharge cells.
- Shares the buses between N_REQ requesters (register file ports, ALU, IDU) with round-robin arbitration and a req/gnt/done handshake.

---
 rtl/sm83_reg_bus_pkg.sv | 23 ++
 rtl/sm83_rr_arbiter.sv | 31 +++
 rtl/sm83_reg_bus_seq.sv | 118 +++++++++++
 3 files changed

// File: rtl/sm83_reg_bus_pkg.sv
// Shared types and constants for the SM83 precharged register-bus sequencer.
package sm83_reg_bus_pkg;

  localparam int unsigned CNT_W = 3;

  localparam logic [2:0] BUS_A = 3'b001;
  localparam logic [2:0] BUS_B = 3'b010;
  localparam logic [2:0] BUS_C = 3'b100;

  typedef enum logic [1:0] {
    PCH   = 2'd0,
    IDLE  = 2'd1,
    DRIVE = 2'd2,
    LATCH = 2'd3
  } reg_bus_state_t;

  // Per-transfer payload captured from the winning requester.
  typedef struct packed {
    logic [2:0] bus;
    logic       zero;
  } xfer_t;

endpackage

// File: rtl/sm83_rr_arbiter.sv
// Combinational round-robin pick: first set req bit at or above rr, wrapping.
module sm83_rr_arbiter #(
  parameter  int unsigned N_REQ = 4,
  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] rr,
  output logic             any_c,
  output logic [N_REQ-1:0] win_c,
  output logic [IDX_W-1:0] win_idx_c
);

  int unsigned k;

  always_comb begin
    any_c     = 1'b0;
    win_c     = '0;
    win_idx_c = '0;
    k         = 0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      k = 32'(rr) + i;
      if (k >= N_REQ) k = k - N_REQ;
      if (!any_c && req[IDX_W'(k)]) begin
        any_c             = 1'b1;
        win_c[IDX_W'(k)]  = 1'b1;
        win_idx_c         = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/sm83_reg_bus_seq.sv
// Precharge -> drive -> latch sequencer and round-robin arbiter for the SM83
// A/B/C register buses.
module sm83_reg_bus_seq
  import sm83_reg_bus_pkg::*;
#(
  parameter  int unsigned N_REQ      = 4,
  parameter  int unsigned PCH_CYCLES = 1,
  parameter  int unsigned DRV_CYCLES = 1,
  localparam int unsigned IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_zero,
  input  logic [3*N_REQ-1:0] req_bus,
  input  logic               flush,
  output logic               pch_n,
  output logic               c_zero,
  output logic [N_REQ-1:0]   gnt,
  output logic [2:0]         bus_sel,
  output logic               latch,
  output logic [N_REQ-1:0]   done
);

  localparam logic [CNT_W-1:0] PCH_INIT = CNT_W'(PCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRV_INIT = CNT_W'(DRV_CYCLES - 1);

  reg_bus_state_t   state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] rr;

  logic             any_c;
  logic [N_REQ-1:0] win_c;
  logic [IDX_W-1:0] win_idx_c;
  logic [IDX_W-1:0] rr_next_c;
  xfer_t            pick_c;

  sm83_rr_arbiter #(.N_REQ(N_REQ)) u_arb (
    .req       (req),
    .rr        (rr),
    .any_c     (any_c),
    .win_c     (win_c),
    .win_idx_c (win_idx_c)
  );

  assign rr_next_c = (win_idx_c == IDX_W'(N_REQ - 1)) ? '0 : win_idx_c + IDX_W'(1);

  // Bus mask and zero flag of the current winner.
  always_comb begin
    pick_c = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win_c[i]) begin
        pick_c.bus  = req_bus[3*i +: 3];
        pick_c.zero = req_zero[i];
      end
    end
  end

  // Single-process FSM; grant, mask and zero-force are cleared together with pch_n falling.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= PCH;
      cnt     <= PCH_INIT;
      rr      <= '0;
      pch_n   <= 1'b0;
      c_zero  <= 1'b0;
      gnt     <= '0;
      bus_sel <= '0;
      latch   <= 1'b0;
      done    <= '0;
    end else begin
      latch <= 1'b0;
      done  <= '0;
      unique case (state)
        PCH, IDLE: begin
          if (state == PCH && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else if (any_c) begin
            state   <= DRIVE;
            cnt     <= DRV_INIT;
            rr      <= rr_next_c;
            pch_n   <= 1'b1;
            gnt     <= win_c;
            bus_sel <= pick_c.bus;
            c_zero  <= pick_c.zero;
          end else begin
            state <= IDLE;
          end
        end
        DRIVE: begin
          if (flush) begin
            state   <= PCH;
            cnt     <= PCH_INIT;
            pch_n   <= 1'b0;
            c_zero  <= 1'b0;
            gnt     <= '0;
            bus_sel <= '0;
          end else if (cnt == '0) begin
            state <= LATCH;
            latch <= 1'b1;
            done  <= gnt;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        LATCH: begin
          state   <= PCH;
          cnt     <= PCH_INIT;
          pch_n   <= 1'b0;
          c_zero  <= 1'b0;
          gnt     <= '0;
          bus_sel <= '0;
        end
      endcase
    end
  end

endmodule
